// File: rtl/mult_pipe_pkg.sv
// Shared stage control record, pipeline depth limits and width helper for mult_pipe_mac.
package mult_pipe_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  // Control tag that travels with every beat; the product field is appended per instance.
  typedef struct packed {
    logic valid;
    logic a_signed;
    logic b_signed;
    logic acc;
  } stage_ctrl_t;

  function automatic int ext_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One enable/reset register slice of the mult_pipe_mac pipeline.
module mult_pipe_stage
  import mult_pipe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] data_d,
  output logic [W-1:0] data_q
);

  // NOTE: non-blocking assignment lets every slice capture its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    // NOTE: rst is tested ahead of en so a reset still clears the slice during a stall.
    if (rst) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/mult_pipe_mac.sv
// Pipelined signed/unsigned multiplier with valid tag and global stall enable.
// Define MULT_PIPE_MAC_ACC_EN to add the in_acc port and turn the last stage into an accumulator.
module mult_pipe_mac
  import mult_pipe_pkg::*;
#(
  parameter int WA     = 18,
  parameter int WB     = 18,
  parameter int STAGES = 3,
  parameter int OUT_W  = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  input  logic             a_signed,
  input  logic             b_signed,
`ifdef MULT_PIPE_MAC_ACC_EN
  input  logic             in_acc,
`endif
  output logic [OUT_W-1:0] o,
  output logic             out_valid
);

  localparam int PW   = WA + WB;
  localparam int AX_W = ext_w(WA);
  localparam int BX_W = ext_w(WB);

  typedef struct packed {
    stage_ctrl_t     ctrl;
    logic [PW-1:0]   product;
  } beat_t;

  typedef struct packed {
    logic             valid;
    logic [OUT_W-1:0] value;
  } out_rec_t;

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mult_pipe_mac: STAGES must lie in 2..4");
  end
  if (OUT_W < PW) begin : g_bad_out_w
    $error("mult_pipe_mac: OUT_W must be at least WA+WB");
  end

  // Stage 0 carries the raw operands {a, b} in the product field; they are multiplied on the way to stage 1.
  function automatic beat_t multiply(input beat_t op);
    logic signed [AX_W-1:0] ax;
    logic signed [BX_W-1:0] bx;
    logic signed [PW-1:0]   full;
    beat_t                  r;
    ax        = {op.ctrl.a_signed & op.product[PW-1], op.product[PW-1:WB]};
    bx        = {op.ctrl.b_signed & op.product[WB-1], op.product[WB-1:0]};
    full      = PW'(ax) * PW'(bx);
    r.ctrl    = op.ctrl;
    r.product = full;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] extend(input beat_t bt);
    logic signed [PW-1:0] p_s;
    p_s = bt.product;
    if (bt.ctrl.a_signed | bt.ctrl.b_signed) begin
      return OUT_W'(p_s);
    end
    return OUT_W'(bt.product);
  endfunction

  logic             acc_in;
  beat_t            beat_d [STAGES];
  beat_t            beat_q [STAGES-1];
  out_rec_t         out_d;
  out_rec_t         out_q;
  logic [OUT_W-1:0] ext_product;

`ifdef MULT_PIPE_MAC_ACC_EN
  assign acc_in = in_acc;
`else
  assign acc_in = 1'b0;
`endif

  always_comb begin
    beat_d[0].ctrl.valid    = in_valid;
    beat_d[0].ctrl.a_signed = a_signed;
    beat_d[0].ctrl.b_signed = b_signed;
    beat_d[0].ctrl.acc      = acc_in;
    beat_d[0].product       = {a, b};
    for (int i = 1; i < STAGES; i++) begin
      beat_d[i] = (i == 1) ? multiply(beat_q[0]) : beat_q[i-1];
    end
  end

  always_comb begin
    ext_product = extend(beat_d[STAGES-1]);
    // NOTE: out_d starts from the held value so every path assigns it and no latch is inferred.
    out_d       = out_q;
    out_d.valid = beat_d[STAGES-1].ctrl.valid;
`ifdef MULT_PIPE_MAC_ACC_EN
    if (beat_d[STAGES-1].ctrl.valid) begin
      out_d.value = beat_d[STAGES-1].ctrl.acc ? out_q.value + ext_product : ext_product;
    end
`else
    out_d.value = ext_product;
`endif
  end

`ifndef MULT_PIPE_MAC_ACC_EN
  logic unused_acc;
  assign unused_acc = beat_d[STAGES-1].ctrl.acc;
`endif

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i < STAGES - 1) begin : g_pipe
      mult_pipe_stage #(.W($bits(beat_t))) u_stage (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .data_d (beat_d[i]),
        .data_q (beat_q[i])
      );
    end else begin : g_out
      mult_pipe_stage #(.W($bits(out_rec_t))) u_stage (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .data_d (out_d),
        .data_q (out_q)
      );
    end
  end

  assign o         = out_q.value;
  assign out_valid = out_q.valid;

endmodule

// File: tb/tb_mult_pipe_mac.sv
// Directed self-checking bench for mult_pipe_mac: default, STAGES=2/4 and narrow-width builds side by side.
module tb_mult_pipe_mac;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, a_signed, b_signed, in_acc;
  logic [17:0] a, b;
  logic [7:0]  a8;
  logic [11:0] b12;
  logic [35:0] o, o_s2, o_s4;
  logic [19:0] o_sm;
  logic        ov, ov_s2, ov_s4, ov_sm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_pipe_mac u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed),
`ifdef MULT_PIPE_MAC_ACC_EN
    .in_acc(in_acc),
`endif
    .o(o), .out_valid(ov)
  );

  mult_pipe_mac #(.STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed),
`ifdef MULT_PIPE_MAC_ACC_EN
    .in_acc(1'b0),
`endif
    .o(o_s2), .out_valid(ov_s2)
  );

  mult_pipe_mac #(.STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed),
`ifdef MULT_PIPE_MAC_ACC_EN
    .in_acc(1'b0),
`endif
    .o(o_s4), .out_valid(ov_s4)
  );

  mult_pipe_mac #(.WA(8), .WB(12), .OUT_W(20)) u_sm (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a8), .b(b12),
    .a_signed(a_signed), .b_signed(b_signed),
`ifdef MULT_PIPE_MAC_ACC_EN
    .in_acc(1'b0),
`endif
    .o(o_sm), .out_valid(ov_sm)
  );

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic        a_s;
    logic        b_s;
    logic        v;
    logic        acc;
    logic [35:0] exp;
  } vec_t;

  localparam int NV = 9;
  localparam int NA = 6;
  vec_t tbl [NV];
  vec_t acc_tbl [NA];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    a        = v.a;
    b        = v.b;
    a_signed = v.a_s;
    b_signed = v.b_s;
    in_valid = v.v;
    in_acc   = v.acc;
  endtask

  // Output of a build with latency lat, observed after stream cycle c.
  task automatic expect_stream(input string tag, input int idx, input logic [35:0] obs_o, input logic obs_v);
    if (idx >= 0 && idx < NV && tbl[idx].v) begin
      check({tag, "_valid"}, 64'(obs_v), 64'd1);
      check({tag, "_o"}, 64'(obs_o), 64'(tbl[idx].exp));
    end else begin
      check({tag, "_idle"}, 64'(obs_v), 64'd0);
    end
  endtask

  initial begin
    tbl[0] = '{18'h3FFFF, 18'd5,     1'b1, 1'b1, 1'b1, 1'b0, 36'hFFFFFFFFB};
    tbl[1] = '{18'h3FFFF, 18'd5,     1'b0, 1'b1, 1'b1, 1'b0, 36'd1310715};
    tbl[2] = '{18'h3FFFF, 18'd5,     1'b1, 1'b1, 1'b1, 1'b0, 36'hFFFFFFFFB};
    tbl[3] = '{18'h3FFFF, 18'd5,     1'b0, 1'b0, 1'b1, 1'b0, 36'd1310715};
    tbl[4] = '{18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 36'hFFFFC0001};
    tbl[5] = '{18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 36'hFFFF80001};
    tbl[6] = '{18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1, 1'b0, 36'h400000000};
    tbl[7] = '{18'h20000, 18'h3FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 36'h800020000};
    tbl[8] = '{18'd11,    18'd13,    1'b0, 1'b0, 1'b0, 1'b0, 36'd0};

    acc_tbl[0] = '{18'd3,     18'd4, 1'b1, 1'b1, 1'b1, 1'b0, 36'd12};
    acc_tbl[1] = '{18'd2,     18'd5, 1'b1, 1'b1, 1'b1, 1'b1, 36'd22};
    acc_tbl[2] = '{18'd9,     18'd9, 1'b1, 1'b1, 1'b0, 1'b1, 36'd22};
    acc_tbl[3] = '{18'h3FFFF, 18'd7, 1'b1, 1'b1, 1'b1, 1'b1, 36'd15};
    acc_tbl[4] = '{18'h3FFFF, 18'd1, 1'b1, 1'b1, 1'b1, 1'b0, 36'hFFFFFFFFF};
    acc_tbl[5] = '{18'd1,     18'd1, 1'b1, 1'b1, 1'b1, 1'b1, 36'd0};

    // Reset while stalled, with a valid beat presented.
    rst = 1'b1; en = 1'b0; in_valid = 1'b1; in_acc = 1'b0;
    a = 18'd77; b = 18'd3; a_signed = 1'b0; b_signed = 1'b0;
    a8 = 8'd0; b12 = 12'd0;
    tick();
    rst = 1'b0;
    check("rst_o", 64'(o), 64'd0);
    check("rst_valid", 64'(ov), 64'd0);
    check("rst_s2_valid", 64'(ov_s2), 64'd0);
    check("rst_s4_valid", 64'(ov_s4), 64'd0);
    check("rst_sm_valid", 64'(ov_sm), 64'd0);

    // Back-to-back stream with mode changes every beat; three depths checked at once.
    en = 1'b1;
    for (int c = 0; c < NV + 3; c++) begin
      if (c < NV) drive(tbl[c]);
      else in_valid = 1'b0;
      tick();
      expect_stream("s3", c - 2, o, ov);
      expect_stream("s2", c - 1, o_s2, ov_s2);
      expect_stream("s4", c - 3, o_s4, ov_s4);
    end

    // Stall for four cycles with three beats in flight.
    in_valid = 1'b1; a_signed = 1'b0; b_signed = 1'b0;
    a = 18'd7; b = 18'd9; tick();
    a = 18'h3FFFF; b = 18'd2; a_signed = 1'b1; b_signed = 1'b1; tick();
    a = 18'd256; b = 18'd256; a_signed = 1'b0; b_signed = 1'b0; tick();
    check("stall_pre_o", 64'(o), 64'd63);
    check("stall_pre_valid", 64'(ov), 64'd1);
    en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      a = 18'(12345 + s); b = 18'd3; a_signed = s[0]; in_valid = 1'b1;
      tick();
      check("stall_hold_o", 64'(o), 64'd63);
      check("stall_hold_valid", 64'(ov), 64'd1);
    end
    en = 1'b1; in_valid = 1'b0;
    tick();
    check("resume1_o", 64'(o), 64'hFFFFFFFFE);
    check("resume1_valid", 64'(ov), 64'd1);
    tick();
    check("resume2_o", 64'(o), 64'h10000);
    check("resume2_valid", 64'(ov), 64'd1);
    tick();
    check("resume3_valid", 64'(ov), 64'd0);

    // Reset with two beats in flight and en low; nothing may emerge afterwards.
    in_valid = 1'b1; a = 18'd5; b = 18'd5; a_signed = 1'b1; b_signed = 1'b1;
    tick();
    a = 18'd6; b = 18'd6;
    tick();
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_o", 64'(o), 64'd0);
    check("midrst_valid", 64'(ov), 64'd0);
    check("midrst_s4_valid", 64'(ov_s4), 64'd0);
    en = 1'b1; in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("midrst_no_stale", 64'(ov), 64'd0);
      check("midrst_s4_no_stale", 64'(ov_s4), 64'd0);
    end

    // Narrow build: 8x12 into a 20-bit result.
    in_valid = 1'b1; a_signed = 1'b0; b_signed = 1'b0; a8 = 8'hFF; b12 = 12'hFFF;
    tick();
    a_signed = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("sm_uu_o", 64'(o_sm), 64'd1044225);
    check("sm_uu_valid", 64'(ov_sm), 64'd1);
    tick();
    check("sm_su_o", 64'(o_sm), 64'hFF001);
    check("sm_su_valid", 64'(ov_sm), 64'd1);
    tick();
    check("sm_idle_valid", 64'(ov_sm), 64'd0);

`ifdef MULT_PIPE_MAC_ACC_EN
    // Accumulate sequence, invalid-beat hold and all-ones wrap.
    for (int c = 0; c < NA + 2; c++) begin
      if (c < NA) drive(acc_tbl[c]);
      else in_valid = 1'b0;
      tick();
      if (c >= 2) begin
        check("acc_o", 64'(o), 64'(acc_tbl[c-2].exp));
        check("acc_valid", 64'(ov), 64'(acc_tbl[c-2].v));
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_pipe_mac.md
Name: mult_pipe_mac

Overview:
- Parametrised pipelined multiplier; successor to the fixed 18x18 signed 3-register DSP multiplier wrapper.
- Adds generic operand widths and selectable pipeline depth.
- Adds runtime per-operand signed/unsigned mode and a valid tag travelling with the data.
- Adds an optional accumulate stage.
- Used by datapath blocks (filters, address scaling, fixed-point scaling) that need a throughput-1 multiply with a global stall enable.

Parameters:
- WA, 18, operand A width (2..36).
- WB, 18, operand B width (2..36).
- STAGES, 3, register stages from operand sample to output (2..4).
- OUT_W, 36, output width; must be >= WA+WB; product extended to OUT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  global clock enable; 0 freezes every register in the block.
- in_valid  in  1  operand beat valid.
- a  in  WA  operand A.
- b  in  WB  operand B.
- a_signed  in  1  1 = A is two's complement, 0 = unsigned.
- b_signed  in  1  1 = B is two's complement, 0 = unsigned.
- in_acc  in  1  accumulate control; only exists when MULT_PIPE_MAC_ACC_EN is defined.
- o  out  OUT_W  result.
- out_valid  out  1  o holds the result of a valid beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: rst=1 at a rising edge clears every stage register, the mode bits, the valid pipe and the accumulator. After that edge o=0 and out_valid=0.
- Reset priority: rst overrides en; reset applies even when en=0.
- Reset mid-operation: all in-flight beats are discarded and no out_valid pulse follows.
- Stage 1 (input register): samples a, b, a_signed, b_signed, in_valid (and in_acc) on each rising edge with en=1.
- Middle stages: STAGES-2 pipeline registers. These carry the product plus valid (and in_acc).
- Last stage: the output register, which drives o and out_valid.
- Latency: a beat sampled at edge k (en=1) appears on o/out_valid after edge k+STAGES-1, counting only edges with en=1.
- Throughput: one beat per enabled cycle. There is no backpressure other than en.
- Stall (en=0): all registers hold, including o and out_valid. A valid beat therefore stays presented for the whole stall.
- Arithmetic:
  - Each operand is extended by one bit: sign-extended if its mode bit is 1, zero-extended otherwise.
  - The (WA+1)x(WB+1) signed product is taken modulo 2^(WA+WB). This is exact for all mode combinations.
  - The product is extended to OUT_W: sign-extended if either mode bit is 1, else zero-extended.
- Invalid beats: still flow through the pipeline. o is updated with their (don't-care) product and out_valid=0. The bench must not check o when out_valid=0.
- Mode changes: mode bits are pipelined with their operands, so modes may change every cycle without a bubble.

Optional Feature:
- Macro: MULT_PIPE_MAC_ACC_EN.
- Defined:
  - The port in_acc exists, and the last stage becomes an OUT_W-bit accumulator.
  - On an enabled edge where the last-stage beat is valid: in_acc=0 loads the extended product; in_acc=1 loads acc + extended product. The sum wraps modulo 2^OUT_W with no saturation.
  - o reflects the accumulator.
  - Invalid beats leave the accumulator and o unchanged and drive out_valid=0.
  - Latency is unchanged.
- Undefined: in_acc is absent and the last stage is a plain output register.

Decomposition:
- Package mult_pipe_pkg holds:
  - the stage record typedef (valid, a_signed, b_signed, acc, product);
  - constants for the STAGES min/max (2/4);
  - the function computing the extended width.
- Sub-module mult_pipe_stage: a single enable/reset register slice, instantiated STAGES times in a generate loop.

Test Plan:
- Default params, a=18'h3FFFF (-1) signed, b=5 signed, in_valid=1 -> o=36'hFFFFFFFFB (-5), out_valid=1 exactly 2 enabled edges after the sampling edge.
- Same operands, a_signed=0, b_signed=1 -> o=262143*5=1310715. Back-to-back beats with alternating modes produce alternating correct results with no bubbles.
- en=0 for 4 cycles mid-stream with 3 beats in flight -> o and out_valid hold, and the sequence resumes in order once en=1.
- rst=1 for one edge with 2 beats in flight, en=0 -> o=0 and out_valid=0 after that edge, and no stale valid appears afterwards.
- STAGES=2 and STAGES=4 builds -> out_valid latency of 1 and 3 enabled edges respectively; WA=8, WB=12, OUT_W=20 with 255 x 4095 unsigned -> 1044225.
- MULT_PIPE_MAC_ACC_EN: beats (3x4, in_acc=0), (2x5, in_acc=1), invalid beat, (-1x7, in_acc=1) -> o sequence 12, 22, (hold 22, out_valid=0), 15. Then the all-ones wrap check: acc=2^36-1 plus 1x1 gives 0.
